// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch unit's memory, decoder and redirect signals.
// The master modport is the fetch unit; slave is its environment.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        dec_ready;
    logic        redirect_valid;
    logic [1:0]  PC_MUX_Select;
    logic [31:0] redirect_base_pc;
    logic [15:0] redirect_imm16;
    logic [25:0] redirect_jtarget;
    logic [31:0] redirect_reg;

    modport master (
        output imem_req, imem_addr, instruction, instr_pc, instr_valid,
        input  imem_ready, imem_rdata, imem_rvalid, dec_ready,
        input  redirect_valid, PC_MUX_Select, redirect_base_pc,
        input  redirect_imm16, redirect_jtarget, redirect_reg
    );

    modport slave (
        input  imem_req, imem_addr, instruction, instr_pc, instr_valid,
        output imem_ready, imem_rdata, imem_rvalid, dec_ready,
        output redirect_valid, PC_MUX_Select, redirect_base_pc,
        output redirect_imm16, redirect_jtarget, redirect_reg
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, issues single-outstanding instruction reads and
// buffers each response for the decoder; execute redirects override everything.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input logic              clk,
    input logic              rst_n,
    instr_fetch_unit_if.master bus
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instruction_q, instruction_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;

    logic        free;
    logic        imem_req;
    logic        transfer;
    logic        load;
    logic [31:0] p4;
    logic [31:0] target;

    assign free     = !instr_valid_q | bus.dec_ready;
    assign transfer = instr_valid_q & bus.dec_ready;
    assign load     = (state_q == S_WAIT) & bus.imem_rvalid;
    // rst_n gates the request so nothing is issued while reset is held.
    assign imem_req = rst_n & (state_q == S_REQ) & free & !bus.redirect_valid;

    assign bus.imem_req    = imem_req;
    assign bus.imem_addr   = pc_q;
    assign bus.instruction = instruction_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;

    always_comb begin
        p4 = bus.redirect_base_pc + 32'd4;
        case (bus.PC_MUX_Select)
            2'b01:   target = p4 + {{14{bus.redirect_imm16[15]}}, bus.redirect_imm16, 2'b00};
            2'b10:   target = {p4[31:28], bus.redirect_jtarget, 2'b00};
            2'b11:   target = bus.redirect_reg & 32'hFFFF_FFFC;
            default: target = p4;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instruction_d = instruction_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        if (bus.redirect_valid) begin
            pc_d          = target;
            instr_valid_d = 1'b0;
            instruction_d = NOP_INSTR;
            if ((state_q == S_WAIT || state_q == S_DROP) && !bus.imem_rvalid)
                state_d = S_DROP;
            else
                state_d = S_REQ;
        end else begin
            if (transfer && !load) begin
                instr_valid_d = 1'b0;
                instruction_d = NOP_INSTR;
            end
            case (state_q)
                S_REQ: begin
                    if (imem_req && bus.imem_ready)
                        state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        instruction_d = bus.imem_rdata;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + 32'd4;
                        state_d       = S_REQ;
                    end
                end
                S_DROP: begin
                    if (bus.imem_rvalid)
                        state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            instruction_q <= NOP_INSTR;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instruction_q <= instruction_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a scoreboard queue of {pc, instruction}
// checked at every decoder transfer, plus cycle-level checks of the fetch port.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [63:0] exp_q[$];

    // Memory model: automatic 1-cycle responder, or manually driven pulses.
    logic        auto_mem = 1'b1;
    logic        acc_n = 1'b0;
    logic [31:0] acc_addr = '0;
    logic        auto_rv = 1'b0;
    logic [31:0] auto_rd = '0;
    logic        man_rv = 1'b0;
    logic [31:0] man_rd = '0;

    assign bus.imem_rvalid = auto_mem ? auto_rv : man_rv;
    assign bus.imem_rdata  = auto_mem ? auto_rd : man_rd;

    always @(negedge clk) begin
        acc_n    = bus.imem_req & bus.imem_ready;
        acc_addr = bus.imem_addr;
    end

    always @(posedge clk) begin
        #1;
        auto_rv = acc_n;
        auto_rd = acc_addr | 32'h2000_0000;
    end

    // Scoreboard monitor: every decoder transfer must match the queue head.
    always @(negedge clk) begin
        if (rst_n && bus.instr_valid && bus.dec_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL xfer_unexpected: got pc=%h instr=%h, required no transfer",
                         bus.instr_pc, bus.instruction);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({bus.instr_pc, bus.instruction} !== e) begin
                    bad++;
                    $display("FAIL xfer: got pc=%h instr=%h, required pc=%h instr=%h",
                             bus.instr_pc, bus.instruction, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] ins);
        exp_q.push_back({pc, ins});
    endtask

    initial begin
        bus.imem_ready       = 1'b1;
        bus.dec_ready        = 1'b1;
        bus.redirect_valid   = 1'b0;
        bus.PC_MUX_Select    = 2'b00;
        bus.redirect_base_pc = '0;
        bus.redirect_imm16   = '0;
        bus.redirect_jtarget = '0;
        bus.redirect_reg     = '0;

        #2;
        chk("rst_req",   {31'd0, bus.imem_req},    32'd0);
        chk("rst_addr",  bus.imem_addr,            32'h0);
        chk("rst_instr", bus.instruction,          32'h0);
        chk("rst_pc",    bus.instr_pc,             32'h0);
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        nxt(); nxt();

        // Straight-line fetch
        push(32'h0, 32'h2000_0000);
        push(32'h4, 32'h2000_0004);
        push(32'h8, 32'h2000_0008);
        rst_n = 1'b1;
        neg(); chk("a0_req", {31'd0, bus.imem_req}, 32'd1); chk("a0_addr", bus.imem_addr, 32'h0);
        nxt(); neg(); chk("a1_valid", {31'd0, bus.instr_valid}, 32'd0); chk("a1_req", {31'd0, bus.imem_req}, 32'd0);
        nxt(); neg(); chk("a2_valid", {31'd0, bus.instr_valid}, 32'd1); chk("a2_addr", bus.imem_addr, 32'h4);
        chk("a2_req", {31'd0, bus.imem_req}, 32'd1);
        nxt(); nxt(); neg(); chk("a4_addr", bus.imem_addr, 32'h8); chk("a4_req", {31'd0, bus.imem_req}, 32'd1);
        nxt(); nxt();

        // Decoder stall with full buffer
        bus.dec_ready = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            neg();
            chk("stall_req",   {31'd0, bus.imem_req},    32'd0);
            chk("stall_instr", bus.instruction,          32'h2000_0008);
            chk("stall_pc",    bus.instr_pc,             32'h8);
            chk("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
            nxt();
        end
        bus.dec_ready = 1'b1;
        neg(); chk("release_req", {31'd0, bus.imem_req}, 32'd1); chk("release_addr", bus.imem_addr, 32'hC);
        nxt(); nxt();

        // Branch redirect flushes the held instruction at pc 0xC
        bus.dec_ready = 1'b0;
        bus.redirect_valid = 1'b1; bus.PC_MUX_Select = 2'b01;
        bus.redirect_base_pc = 32'h100; bus.redirect_imm16 = 16'hFFFE;
        neg(); chk("br_pre_pc", bus.instr_pc, 32'hC); chk("br_req", {31'd0, bus.imem_req}, 32'd0);
        nxt();
        bus.redirect_valid = 1'b0; bus.dec_ready = 1'b1;
        push(32'h0FC, 32'h2000_00FC);
        neg(); chk("br_flush", {31'd0, bus.instr_valid}, 32'd0); chk("br_addr", bus.imem_addr, 32'h0FC);
        chk("br_req2", {31'd0, bus.imem_req}, 32'd1);
        nxt(); nxt();
        neg(); chk("br_valid", {31'd0, bus.instr_valid}, 32'd1);
        auto_mem = 1'b0;
        nxt();

        // Jump redirect while waiting; late response must be dropped
        bus.redirect_valid = 1'b1; bus.PC_MUX_Select = 2'b10;
        bus.redirect_base_pc = 32'h4000_0010; bus.redirect_jtarget = 26'h0000040;
        neg(); chk("j_req", {31'd0, bus.imem_req}, 32'd0);
        nxt();
        bus.redirect_valid = 1'b0; man_rv = 1'b1; man_rd = 32'hDEAD_BEEF;
        neg(); chk("j_drop_req", {31'd0, bus.imem_req}, 32'd0); chk("j_addr", bus.imem_addr, 32'h4000_0100);
        chk("j_valid", {31'd0, bus.instr_valid}, 32'd0);
        nxt();
        man_rv = 1'b0;
        neg(); chk("j_req2", {31'd0, bus.imem_req}, 32'd1); chk("j_addr2", bus.imem_addr, 32'h4000_0100);
        chk("j_valid2", {31'd0, bus.instr_valid}, 32'd0);
        nxt();

        // Register redirect coincident with the response
        man_rv = 1'b1; man_rd = 32'h1111_1111;
        bus.redirect_valid = 1'b1; bus.PC_MUX_Select = 2'b11; bus.redirect_reg = 32'h0000_2003;
        neg(); chk("r_req", {31'd0, bus.imem_req}, 32'd0);
        nxt();
        man_rv = 1'b0; bus.redirect_valid = 1'b0;
        push(32'h2000, 32'h2222_2222);
        neg(); chk("r_valid", {31'd0, bus.instr_valid}, 32'd0); chk("r_req2", {31'd0, bus.imem_req}, 32'd1);
        chk("r_addr", bus.imem_addr, 32'h2000);
        nxt();
        man_rv = 1'b1; man_rd = 32'h2222_2222;
        nxt();

        // Redirect to the top of the address space, then wrap
        man_rv = 1'b0;
        bus.redirect_valid = 1'b1; bus.redirect_reg = 32'hFFFF_FFFF;
        neg(); chk("w_pc", bus.instr_pc, 32'h2000); chk("w_req", {31'd0, bus.imem_req}, 32'd0);
        nxt();
        bus.redirect_valid = 1'b0;
        push(32'hFFFF_FFFC, 32'h3333_3333);
        neg(); chk("w_addr", bus.imem_addr, 32'hFFFF_FFFC); chk("w_req2", {31'd0, bus.imem_req}, 32'd1);
        chk("w_flush", {31'd0, bus.instr_valid}, 32'd0);
        nxt();
        man_rv = 1'b1; man_rd = 32'h3333_3333;
        nxt();
        man_rv = 1'b0;
        neg(); chk("w_ipc", bus.instr_pc, 32'hFFFF_FFFC); chk("w_wrap", bus.imem_addr, 32'h0);
        chk("w_req3", {31'd0, bus.imem_req}, 32'd1);
        nxt();

        // Reset asserted while waiting for a response
        rst_n = 1'b0;
        #1;
        chk("mr_req",   {31'd0, bus.imem_req},    32'd0);
        chk("mr_addr",  bus.imem_addr,            32'h0);
        chk("mr_instr", bus.instruction,          32'h0);
        chk("mr_pc",    bus.instr_pc,             32'h0);
        chk("mr_valid", {31'd0, bus.instr_valid}, 32'd0);
        nxt();
        rst_n = 1'b1; man_rv = 1'b1; man_rd = 32'h4444_4444;
        push(32'h0, 32'h5555_5555);
        neg(); chk("st_req", {31'd0, bus.imem_req}, 32'd1); chk("st_addr", bus.imem_addr, 32'h0);
        chk("st_valid", {31'd0, bus.instr_valid}, 32'd0);
        nxt();
        man_rv = 1'b0;
        neg(); chk("st_valid2", {31'd0, bus.instr_valid}, 32'd0);
        nxt();
        man_rv = 1'b1; man_rd = 32'h5555_5555;
        nxt();
        man_rv = 1'b0;
        neg(); chk("st_instr", bus.instruction, 32'h5555_5555);
        nxt(); nxt();

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
